// File: rtl/rr_arbiter_4_if.sv
// Handshake bundle between four requesters and the round-robin arbiter.
interface rr_arbiter_4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       preempt;

    modport master (output en, req, input gnt, gnt_idx, busy, preempt);
    modport slave  (input en, req, output gnt, gnt_idx, busy, preempt);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with break-before-make grants and a hold-time
// limit that lets a waiting requester preempt a long-running owner.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_4_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    // With no limit the counter is parked at zero; it is never compared.
    localparam logic [CNT_W-1:0] HOLD_TOP = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [3:0]       gnt_q, gnt_n;
    logic [1:0]       idx_q, idx_n;
    logic             busy_q, busy_n;
    logic             pre_q, pre_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       own, others;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign own    = bus.req[idx_q];
    assign others = |(bus.req & ~(4'b0001 << idx_q));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        pre_n   = 1'b0;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.en && win_vld) begin
                    state_n = GRANT;
                    idx_n   = win_idx;
                    gnt_n   = 4'b0001 << win_idx;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!own) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                    ptr_n   = idx_q + 2'd1;
                end else if (MAX_HOLD != 0 && cnt == HOLD_TOP && others) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                    ptr_n   = idx_q + 2'd1;
                    pre_n   = 1'b1;
                end else if (cnt != HOLD_TOP) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            gnt_q  <= 4'b0000;
            idx_q  <= 2'd0;
            busy_q <= 1'b0;
            pre_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt_q  <= gnt_n;
            idx_q  <= idx_n;
            busy_q <= busy_n;
            pre_q  <= pre_n;
            cnt    <= cnt_n;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = pre_q;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench: two arbiters (hold limit 4 and 16), expectations queued per cycle.
module tb_rr_arbiter_4;
    logic clk;
    logic rst_a, rst_b;

    rr_arbiter_4_if ia();
    rr_arbiter_4_if ib();

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(3)) u_a (.clk(clk), .rst(rst_a), .bus(ia));
    rr_arbiter_4 u_b (.clk(clk), .rst(rst_b), .bus(ib));

    typedef struct packed {
        logic       en;
        logic [3:0] req;
        logic [7:0] exp;
    } row_t;

    row_t       rows[$];
    logic [7:0] exp_q[$];
    row_t       r;
    logic [7:0] e, got;
    int         total, bad, n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected {gnt, gnt_idx, busy, preempt}
    function automatic logic [7:0] gx(input int o);
        logic [1:0] i;
        i = 2'(o);
        return {4'b0001 << i, i, 1'b1, 1'b0};
    endfunction
    function automatic logic [7:0] ix(input int o);
        return {4'b0000, 2'(o), 1'b0, 1'b0};
    endfunction
    function automatic logic [7:0] px(input int o);
        return {4'b0000, 2'(o), 1'b0, 1'b1};
    endfunction
    function automatic row_t rw(input logic en, input logic [3:0] req, input logic [7:0] ex);
        row_t t;
        t.en  = en;
        t.req = req;
        t.exp = ex;
        return t;
    endfunction

    task test_reset;
        #2;
        got = {ia.gnt, ia.gnt_idx, ia.busy, ia.preempt};
        total++;
        if (got !== 8'h00) begin bad++; $display("FAIL reset_a got=%b exp=%b", got, 8'h00); end
        got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
        total++;
        if (got !== 8'h00) begin bad++; $display("FAIL reset_b got=%b exp=%b", got, 8'h00); end
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) rows.push_back(rw(1'b1, 4'b0000, ix(0)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ib.en = r.en; ib.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL idle cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    task test_basic;
        rows.push_back(rw(1'b1, 4'b1010, gx(1)));
        rows.push_back(rw(1'b1, 4'b1010, gx(1)));
        rows.push_back(rw(1'b1, 4'b1000, ix(1)));
        rows.push_back(rw(1'b1, 4'b1000, gx(3)));
        rows.push_back(rw(1'b1, 4'b0000, ix(3)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ib.en = r.en; ib.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    task test_rotate;
        for (int rnd = 0; rnd < 8; rnd++) begin
            for (int k = 0; k < 4; k++) rows.push_back(rw(1'b1, 4'b1111, gx(rnd % 4)));
            rows.push_back(rw(1'b1, 4'b1111, px(rnd % 4)));
        end
        rows.push_back(rw(1'b1, 4'b0000, ix(3)));
        // release coinciding with the hold limit counts as a release
        for (int k = 0; k < 4; k++) rows.push_back(rw(1'b1, 4'b0011, gx(0)));
        rows.push_back(rw(1'b1, 4'b0010, ix(0)));
        rows.push_back(rw(1'b1, 4'b0010, gx(1)));
        rows.push_back(rw(1'b1, 4'b0000, ix(1)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ia.en = r.en; ia.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ia.gnt, ia.gnt_idx, ia.busy, ia.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL rotate cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    task test_hold_limit;
        for (int k = 0; k < 40; k++) rows.push_back(rw(1'b1, 4'b0100, gx(2)));
        rows.push_back(rw(1'b1, 4'b0101, px(2)));
        for (int k = 0; k < 3; k++) rows.push_back(rw(1'b1, 4'b0101, gx(0)));
        rows.push_back(rw(1'b1, 4'b0000, ix(0)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ib.en = r.en; ib.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL hold cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    task test_enable;
        rows.push_back(rw(1'b1, 4'b0010, gx(1)));
        for (int k = 0; k < 3; k++) rows.push_back(rw(1'b0, 4'b0010, gx(1)));
        rows.push_back(rw(1'b0, 4'b0000, ix(1)));
        for (int k = 0; k < 3; k++) rows.push_back(rw(1'b0, 4'b1111, ix(1)));
        rows.push_back(rw(1'b1, 4'b1111, gx(2)));
        rows.push_back(rw(1'b1, 4'b0000, ix(2)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ib.en = r.en; ib.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL enable cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    task test_async_reset;
        ib.en = 1'b1; ib.req = 4'b0010; exp_q.push_back(gx(1));
        @(posedge clk); @(negedge clk);
        e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
        total++;
        if (got !== e) begin bad++; $display("FAIL arst_pre got=%b exp=%b", got, e); end
        #1 rst_b = 1'b1;
        #1;
        got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
        total++;
        if (got !== 8'h00) begin bad++; $display("FAIL arst_drop got=%b exp=%b", got, 8'h00); end
        ib.req = 4'b0000;
        @(negedge clk);
        rst_b = 1'b0;
        // ptr must be back at 0: req 1001 picks 0, not 3
        rows.push_back(rw(1'b1, 4'b1001, gx(0)));
        rows.push_back(rw(1'b1, 4'b0000, ix(0)));
        rows.push_back(rw(1'b1, 4'b0001, gx(0)));
        rows.push_back(rw(1'b1, 4'b0000, ix(0)));
        n = 0;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            ib.en = r.en; ib.req = r.req; exp_q.push_back(r.exp);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); got = {ib.gnt, ib.gnt_idx, ib.busy, ib.preempt};
            total++;
            if (got !== e) begin bad++; $display("FAIL arst cyc=%0d got=%b exp=%b", n, got, e); end
            n++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.en = 1'b0; ia.req = 4'b0000;
        ib.en = 1'b0; ib.req = 4'b0000;
        test_reset();
        test_basic();
        test_rotate();
        test_hold_limit();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
